// File: rtl/spi_request_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals around the request arbiter.
// The master modport is the arbiter's view. The slave modport is the surrounding logic's view.
interface spi_request_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req;
    logic [24*NUM_REQ-1:0] wdata;
    logic [3*NUM_REQ-1:0]  wdiv;
    logic [NUM_REQ-1:0]    ack;
    logic [NUM_REQ-1:0]    err;
    logic [23:0]           rdata;
    logic                  busy;
    logic [ID_W-1:0]       grant_id;
    logic                  spi_start;
    logic [23:0]           spi_data_in;
    logic [2:0]            spi_clock_div;
    logic                  spi_done;
    logic [23:0]           spi_data_out;

    modport master (
        input  req, wdata, wdiv, spi_done, spi_data_out,
        output ack, err, rdata, busy, grant_id, spi_start, spi_data_in, spi_clock_div
    );

    modport slave (
        output req, wdata, wdiv, spi_done, spi_data_out,
        input  ack, err, rdata, busy, grant_id, spi_start, spi_data_in, spi_clock_div
    );
endinterface

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter that shares one 24-bit SPI master among NUM_REQ requesters.
// It runs the start/done handshake and has a watchdog that aborts transfers whose done never arrives.
module spi_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    spi_request_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic [2:0]         state_reg;
    logic [ID_W-1:0]    last_grant_reg;
    logic [ID_W-1:0]    grant_id_reg;
    logic [WD_W-1:0]    wd_reg;
    logic               done_meta_reg;
    logic               done_s_reg;
    logic [NUM_REQ-1:0] ack_reg;
    logic [NUM_REQ-1:0] err_reg;
    logic [23:0]        rdata_reg;
    logic               busy_reg;
    logic               spi_start_reg;
    logic [23:0]        spi_data_in_reg;
    logic [2:0]         spi_clock_div_reg;

    logic [23:0]        wdata_arr [NUM_REQ];
    logic [2:0]         wdiv_arr  [NUM_REQ];
    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign wdata_arr[gi] = bus.wdata[24*gi +: 24];
            assign wdiv_arr[gi]  = bus.wdiv[3*gi +: 3];
        end
    endgenerate

    // Walk from the farthest candidate to the nearest one, so the requester closest after last_grant wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            last_grant_reg    <= ID_W'(NUM_REQ - 1);
            grant_id_reg      <= '0;
            wd_reg            <= '0;
            done_meta_reg     <= 1'b0;
            done_s_reg        <= 1'b0;
            ack_reg           <= '0;
            err_reg           <= '0;
            rdata_reg         <= '0;
            busy_reg          <= 1'b0;
            spi_start_reg     <= 1'b0;
            spi_data_in_reg   <= '0;
            spi_clock_div_reg <= '0;
        end else begin
            done_meta_reg <= bus.spi_done;
            done_s_reg    <= done_meta_reg;
            ack_reg       <= '0;
            err_reg       <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id_reg      <= pick_id;
                        spi_data_in_reg   <= wdata_arr[pick_id];
                        spi_clock_div_reg <= wdiv_arr[pick_id];
                        busy_reg          <= 1'b1;
                        state_reg         <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    spi_start_reg <= 1'b1;
                    wd_reg        <= '0;
                    state_reg     <= ST_START;
                end
                ST_START: begin
                    // A done that arrives in the same cycle as watchdog expiry still counts as a successful transfer.
                    if (done_s_reg) begin
                        spi_start_reg          <= 1'b0;
                        ack_reg[grant_id_reg]  <= 1'b1;
                        rdata_reg              <= bus.spi_data_out;
                        state_reg              <= ST_CAPTURE;
                    end else if (wd_reg == WD_LAST) begin
                        spi_start_reg          <= 1'b0;
                        ack_reg[grant_id_reg]  <= 1'b1;
                        err_reg[grant_id_reg]  <= 1'b1;
                        wd_reg                 <= '0;
                        state_reg              <= ST_RELEASE;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    wd_reg    <= '0;
                    state_reg <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!done_s_reg || wd_reg == WD_LAST) begin
                        last_grant_reg <= grant_id_reg;
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack           = ack_reg;
    assign bus.err           = err_reg;
    assign bus.rdata         = rdata_reg;
    assign bus.busy          = busy_reg;
    assign bus.grant_id      = grant_id_reg;
    assign bus.spi_start     = spi_start_reg;
    assign bus.spi_data_in   = spi_data_in_reg;
    assign bus.spi_clock_div = spi_clock_div_reg;
endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed bench for spi_request_arbiter with a simple SPI master model.
// The model raises done (2 + divider) cycles after start and returns data_in XOR a mask.
module tb_spi_request_arbiter;
    logic        clock;
    logic        reset;
    logic        model_en;
    logic [23:0] miso_mask;
    int          cyc;
    int          done_rise_cyc;
    int          start_len;
    int          checks;
    int          errors;

    spi_request_arbiter_if #(.NUM_REQ(4)) bus ();

    spi_request_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // SPI master model
    initial begin
        int  cnt;
        logic prev_start;
        cnt = 0;
        prev_start = 1'b0;
        start_len = 0;
        done_rise_cyc = 0;
        bus.spi_done = 1'b0;
        bus.spi_data_out = '0;
        forever begin
            @(negedge clock);
            if (reset || !model_en) begin
                bus.spi_done = 1'b0;
                cnt = 0;
            end else if (bus.spi_start) begin
                start_len = prev_start ? start_len + 1 : 1;
                if (!bus.spi_done) begin
                    if (cnt == 2 + int'(bus.spi_clock_div)) begin
                        bus.spi_done = 1'b1;
                        bus.spi_data_out = bus.spi_data_in ^ miso_mask;
                        done_rise_cyc = cyc;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                bus.spi_done = 1'b0;
                cnt = 0;
            end
            prev_start = bus.spi_start;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.ack == '0 && n < 200);
        check_eq({tag, "_ack_seen"}, 32'(bus.ack != '0), 1);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.spi_start && n < 200);
        check_eq({tag, "_start_seen"}, 32'(bus.spi_start), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int          exp_id [5];
        int          div_tab [4];
        logic [23:0] exp_rd [4];
        logic [3:0]  exp_ack;
        int          g;
        int          cyc_start;

        exp_id  = '{0, 1, 2, 3, 0};
        div_tab = '{0, 7, 2, 5};
        exp_rd  = '{24'hF0F0F0, 24'hCC9966, 24'h5A3C0F, 24'h2152FE};
        checks = 0;
        errors = 0;
        reset = 1'b1;
        model_en = 1'b1;
        miso_mask = 24'hA5C3F0 ^ 24'h123456;
        bus.req = '0;
        bus.wdata = '0;
        bus.wdiv = '0;
        repeat (3) @(negedge clock);

        check_eq("rst_ack", 32'(bus.ack), 0);
        check_eq("rst_err", 32'(bus.err), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_start", 32'(bus.spi_start), 0);
        check_eq("rst_rdata", 32'(bus.rdata), 0);
        reset = 1'b0;
        @(negedge clock);

        // Single requester 2
        bus.wdata[71:48] = 24'hA5C3F0;
        bus.wdiv[8:6] = 3'd3;
        bus.req = 4'b0100;
        @(negedge clock);
        check_eq("t1_busy_arm", 32'(bus.busy), 1);
        check_eq("t1_grant_id", 32'(bus.grant_id), 2);
        check_eq("t1_data_in", 32'(bus.spi_data_in), 32'h00A5C3F0);
        check_eq("t1_div", 32'(bus.spi_clock_div), 3);
        check_eq("t1_start_arm", 32'(bus.spi_start), 0);
        @(negedge clock);
        check_eq("t1_start", 32'(bus.spi_start), 1);
        wait_ack("t1");
        bus.req = '0;
        check_eq("t1_ack", 32'(bus.ack), 32'b0100);
        check_eq("t1_err", 32'(bus.err), 0);
        check_eq("t1_rdata", 32'(bus.rdata), 32'h00123456);
        check_eq("t1_ack_latency", 32'(cyc - done_rise_cyc), 3);
        @(negedge clock);
        check_eq("t1_ack_single", 32'(bus.ack), 0);
        check_eq("t1_div_release", 32'(bus.spi_clock_div), 3);
        wait_idle("t1");
        check_eq("t1_rdata_held", 32'(bus.rdata), 32'h00123456);

        // Round robin with all four requesting from reset
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.wdata = {24'hDEAD01, 24'hA5C3F0, 24'h336699, 24'h0F0F0F};
        bus.wdiv = {3'd5, 3'd2, 3'd7, 3'd0};
        miso_mask = 24'hFFFFFF;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack($sformatf("rr%0d", k));
            if (k == 4) bus.req = '0;
            g = exp_id[k];
            exp_ack = 4'(1 << g);
            check_eq($sformatf("rr%0d_ack", k), 32'(bus.ack), 32'(exp_ack));
            check_eq($sformatf("rr%0d_err", k), 32'(bus.err), 0);
            check_eq($sformatf("rr%0d_grant", k), 32'(bus.grant_id), 32'(g));
            check_eq($sformatf("rr%0d_rdata", k), 32'(bus.rdata), 32'(exp_rd[g]));
            check_eq($sformatf("rr%0d_div", k), 32'(bus.spi_clock_div), 32'(div_tab[g]));
            check_eq($sformatf("rr%0d_start_len", k), 32'(start_len), 32'(5 + div_tab[g]));
        end
        wait_idle("rr");

        // Watchdog timeout with done tied low
        model_en = 1'b0;
        bus.req = 4'b0010;
        wait_start("to");
        bus.req = '0;
        cyc_start = cyc;
        wait_ack("to");
        check_eq("to_latency", 32'(cyc - cyc_start), 16);
        check_eq("to_ack", 32'(bus.ack), 32'b0010);
        check_eq("to_err", 32'(bus.err), 32'b0010);
        check_eq("to_rdata_kept", 32'(bus.rdata), 32'h00F0F0F0);
        @(negedge clock);
        check_eq("to_start_low", 32'(bus.spi_start), 0);
        check_eq("to_err_single", 32'(bus.err), 0);
        wait_idle("to");
        model_en = 1'b1;
        bus.req = 4'b1000;
        wait_ack("to_next");
        bus.req = '0;
        check_eq("to_next_ack", 32'(bus.ack), 32'b1000);
        check_eq("to_next_err", 32'(bus.err), 0);
        check_eq("to_next_rdata", 32'(bus.rdata), 32'h002152FE);
        wait_idle("to_next");

        // Reset in START
        bus.req = 4'b0100;
        wait_start("rs");
        reset = 1'b1;
        @(negedge clock);
        check_eq("rs_busy", 32'(bus.busy), 0);
        check_eq("rs_start", 32'(bus.spi_start), 0);
        check_eq("rs_grant", 32'(bus.grant_id), 0);
        check_eq("rs_rdata", 32'(bus.rdata), 0);
        check_eq("rs_data_in", 32'(bus.spi_data_in), 0);
        check_eq("rs_div", 32'(bus.spi_clock_div), 0);
        check_eq("rs_ack_err", 32'({bus.ack, bus.err}), 0);
        reset = 1'b0;
        bus.req = 4'b0101;
        @(negedge clock);
        check_eq("rs_regrant", 32'(bus.grant_id), 0);
        bus.req = '0;
        wait_ack("rs");
        check_eq("rs_ack", 32'(bus.ack), 32'b0001);
        wait_idle("rs");

        // Grantee drops req during START
        bus.req = 4'b0010;
        wait_start("dr");
        bus.req = '0;
        wait_ack("dr");
        check_eq("dr_ack", 32'(bus.ack), 32'b0010);
        check_eq("dr_rdata", 32'(bus.rdata), 32'h00CC9966);
        wait_idle("dr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
